// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (G0=111, G1=101) with frame indexing.
// One data bit is accepted per handshake and one registered 2-bit symbol is produced
// one cycle later. sym_index/frame_start/frame_end pair each symbol with its
// position in the frame.
// Build option: define TAIL_FLUSH_EN to append two zero tail symbols per frame and
// force the trellis back to state 00 at every frame boundary. Without it the encoder
// streams, and its shift register carries across frame boundaries.
module conv_encoder #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  input  logic             valid_in,
  input  logic             data_in,
  output logic             ready_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [1:0]       encoded_out,
  output logic [IDX_W-1:0] sym_index,
  output logic             frame_start,
  output logic             frame_end
);

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

`ifdef TAIL_FLUSH_EN
  localparam logic [IDX_W-1:0] LAST_TAIL = IDX_W'(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FLUSH = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       shreg_q, shreg_d;   // {s1,s0}, s1 holds the most recent bit
  logic [IDX_W-1:0] count_q, count_d;   // index the next symbol of the frame will carry
  logic             valid_d;
  logic [1:0]       enc_d;
  logic [IDX_W-1:0] idx_d;
  logic             fs_d;
  logic             fe_d;
  logic             out_free;
  logic             accept;

  // Handshake, next-state, and next-symbol logic
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    count_d  = count_q;
    valid_d  = valid_out;
    enc_d    = encoded_out;
    idx_d    = sym_index;
    fs_d     = frame_start;
    fe_d     = frame_end;

    out_free = !valid_out || ready_out;
`ifdef TAIL_FLUSH_EN
    ready_in = rst && out_free && !refresh && (state_q != FLUSH);
`else
    ready_in = rst && out_free && !refresh;
`endif
    accept   = valid_in && ready_in;

    if (refresh) begin
      // Frame restart: drop any pending symbol and discard the partial frame
      state_d = IDLE;
      shreg_d = 2'b00;
      count_d = '0;
      valid_d = 1'b0;
      enc_d   = 2'b00;
      idx_d   = '0;
      fs_d    = 1'b0;
      fe_d    = 1'b0;
    end else begin
      // A consumed symbol with nothing new behind it leaves the slot empty
      if (out_free) begin
        valid_d = 1'b0;
      end

      if (accept) begin
        valid_d = 1'b1;
        enc_d   = {data_in ^ shreg_q[1] ^ shreg_q[0], data_in ^ shreg_q[0]};
        shreg_d = {data_in, shreg_q[1]};
        idx_d   = count_q;
        fs_d    = (state_q == IDLE);
        fe_d    = 1'b0;
        if (count_q == LAST_DATA) begin
`ifdef TAIL_FLUSH_EN
          state_d = FLUSH;
          count_d = count_q + IDX_ONE;
`else
          state_d = IDLE;
          count_d = '0;
          fe_d    = 1'b1;
`endif
        end else begin
          state_d = DATA;
          count_d = count_q + IDX_ONE;
        end
      end
`ifdef TAIL_FLUSH_EN
      else if ((state_q == FLUSH) && out_free) begin
        // Tail symbol: encode an injected zero bit
        valid_d = 1'b1;
        enc_d   = {shreg_q[1] ^ shreg_q[0], shreg_q[0]};
        shreg_d = {1'b0, shreg_q[1]};
        idx_d   = count_q;
        fs_d    = 1'b0;
        if (count_q == LAST_TAIL) begin
          fe_d    = 1'b1;
          state_d = IDLE;
          count_d = '0;
          shreg_d = 2'b00;
        end else begin
          fe_d    = 1'b0;
          count_d = count_q + IDX_ONE;
        end
      end
`endif
    end
  end

  // State, trellis, counter and output symbol registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= 2'b00;
      count_q     <= '0;
      valid_out   <= 1'b0;
      encoded_out <= 2'b00;
      sym_index   <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      valid_out   <= valid_d;
      encoded_out <= enc_d;
      sym_index   <= idx_d;
      frame_start <= fs_d;
      frame_end   <= fe_d;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: a behavioural encoder model pushes expected
// symbols into a queue on every accepted bit; symbols are popped and compared as the
// DUT hands them downstream. Honours TAIL_FLUSH_EN the same way as the design.
module tb_conv_encoder;

  localparam int unsigned FL = 8;
  localparam int unsigned IW = 4;

`ifdef TAIL_FLUSH_EN
  localparam int TAIL_ON = 1;
`else
  localparam int TAIL_ON = 0;
`endif

  typedef struct packed {
    logic [1:0]    enc;
    logic [IW-1:0] idx;
    logic          fs;
    logic          fe;
  } sym_t;

  logic          clk;
  logic          rst;
  logic          refresh;
  logic          valid_in;
  logic          data_in;
  logic          ready_in;
  logic          valid_out;
  logic          ready_out;
  logic [1:0]    encoded_out;
  logic [IW-1:0] sym_index;
  logic          frame_start;
  logic          frame_end;

  conv_encoder #(.FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .refresh     (refresh),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .encoded_out (encoded_out),
    .sym_index   (sym_index),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_err = 0;
  sym_t exp_q[$];
  logic [1:0] m_s = 2'b00;
  int   m_cnt = 0;
  logic hold_v = 1'b0;
  logic [1:0]    hold_enc;
  logic [IW-1:0] hold_idx;
  int   vec[8] = '{1, 0, 1, 1, 0, 0, 0, 0};

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference encoder: queue the symbol(s) produced by one accepted data bit
  task automatic model_accept(input logic d);
    sym_t e;
    e.enc = {d ^ m_s[1] ^ m_s[0], d ^ m_s[0]};
    e.idx = IW'(m_cnt);
    e.fs  = (m_cnt == 0);
    e.fe  = (TAIL_ON == 0) && (m_cnt == FL - 1);
    exp_q.push_back(e);
    m_s = {d, m_s[1]};
    m_cnt++;
    if (m_cnt == FL) begin
      if (TAIL_ON != 0) begin
        for (int t = 0; t < 2; t++) begin
          e.enc = {m_s[1] ^ m_s[0], m_s[0]};
          e.idx = IW'(FL + t);
          e.fs  = 1'b0;
          e.fe  = (t == 1);
          exp_q.push_back(e);
          m_s = {1'b0, m_s[1]};
        end
        m_s = 2'b00;
      end
      m_cnt = 0;
    end
  endtask

  // One clock cycle: drive on the falling edge, then evaluate what the next rising edge will do
  task automatic step(input logic v, input logic d, input logic ro, input logic rf,
                      input logic r, output logic acc);
    sym_t e;
    @(negedge clk);
    valid_in  = v;
    data_in   = d;
    ready_out = ro;
    refresh   = rf;
    rst       = r;
    #1;
    acc = 1'b0;
    if (hold_v) begin
      check("hold_vld", int'(valid_out), 1);
      check("hold_enc", int'(encoded_out), int'(hold_enc));
      check("hold_idx", int'(sym_index), int'(hold_idx));
    end
    if (r && !rf) begin
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_sym", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("enc", int'(encoded_out), int'(e.enc));
          check("idx", int'(sym_index), int'(e.idx));
          check("fstart", int'(frame_start), int'(e.fs));
          check("fend", int'(frame_end), int'(e.fe));
        end
      end
      if (valid_in && ready_in) begin
        acc = 1'b1;
        model_accept(data_in);
      end
      hold_v   = valid_out && !ready_out;
      hold_enc = encoded_out;
      hold_idx = sym_index;
    end else begin
      check(r ? "rdy_refresh" : "rdy_reset", int'(ready_in), 0);
      exp_q.delete();
      m_s    = 2'b00;
      m_cnt  = 0;
      hold_v = 1'b0;
    end
  endtask

  // Present one bit until the encoder takes it, with a bounded wait
  task automatic send(input logic d);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      step(1'b1, d, 1'b1, 1'b0, 1'b1, acc);
      guard++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   i;
    int   low;
    int   guard;
    rst = 1'b0; refresh = 1'b0; valid_in = 1'b0; data_in = 1'b0; ready_out = 1'b0;

    // Reset held two cycles with valid_in high
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    check("rst_valid", int'(valid_out), 0);
    check("rst_enc", int'(encoded_out), 0);
    check("rst_idx", int'(sym_index), 0);
    check("rst_fstart", int'(frame_start), 0);
    check("rst_fend", int'(frame_end), 0);

    // Known vector, streaming at full rate into the first bit of the next frame
    step(1'b1, 1'(vec[0]), 1'b1, 1'b0, 1'b1, acc);
    check("rdy_release", int'(ready_in), 1);
    i = acc ? 1 : 0;
    guard = 0;
    while (i < 8 && guard < 40) begin
      step(1'b1, 1'(vec[i]), 1'b1, 1'b0, 1'b1, acc);
      if (acc) i++;
      guard++;
    end
    low = 0;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      step(1'b1, 1'(vec[0]), 1'b1, 1'b0, 1'b1, acc);
      if (!acc) low++;
      guard++;
    end
    check("flush_stall_cycles", low, (TAIL_ON != 0) ? 2 : 0);

    // Second frame of the same vector with a 3-cycle downstream stall mid-frame
    for (int b = 1; b < 8; b++) begin
      if (b == 4) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b1, 1'(vec[b]), 1'b0, 1'b0, 1'b1, acc);
          check("bp_ready_in", int'(ready_in), 0);
        end
      end
      send(1'(vec[b]));
    end
    idle_cycles(4);
    check("q_empty_vec", exp_q.size(), 0);

    // Refresh after 1,1,0 then restart with 1,0
    send(1'b1); send(1'b1); send(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    check("rf_valid_drop", int'(valid_out), 0);
    send(1'b1); send(1'b0);
    for (int b = 0; b < 6; b++) send(1'($urandom_range(0, 1)));
    idle_cycles(4);
    check("q_empty_rf", exp_q.size(), 0);

    // Reset right after the last data bit (mid-FLUSH when tails are enabled)
    for (int b = 0; b < 8; b++) send(1'(vec[b]));
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    check("rst_flush_valid", int'(valid_out), 0);
    for (int b = 0; b < 8; b++) send(1'($urandom_range(0, 1)));
    idle_cycles(4);
    check("q_empty_rst", exp_q.size(), 0);

    // Random traffic, backpressure and occasional refresh
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0), 1'b1, acc);
    end
    idle_cycles(6);
    check("q_empty_final", exp_q.size(), 0);
    check("final_valid", int'(valid_out), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
